// File: rtl/typing_tracker.sv
// Typing-game progress controller: compares typed keys against target text, tracks cursor/errors/countdown, decides WIN/LOSE.
// Latency: accepted key or button pulse updates Q/cur/err_cnt on the next CLK edge; key_ready is combinational from Q.
// Backpressure: key_ready is high only in RUN; keys offered in any other state are dropped. Countdown enabled by TYPING_TIME_LIMIT_EN.
module typing_tracker #(
    parameter int CLK_HZ     = 40_000_000,
    parameter int TEXT_LEN   = 200,
    parameter int MAX_ERR    = 10,
    parameter int TIME_LIMIT = 120
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start_btn,
    input  logic          pause_btn,
    input  logic          key_valid,
    input  logic [5:0]    key_code,
    output logic          key_ready,
    input  logic [1199:0] text,
    output logic [2:0]    Q,
    output logic [9:0]    cur,
    output logic [7:0]    err_cnt,
    output logic [7:0]    sec_left
);

    typedef enum logic [2:0] {
        ST_STOP  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_t;

    // Reject out-of-range parameterisations at elaboration time.
    if (CLK_HZ < 1 || TEXT_LEN < 1 || TEXT_LEN > 200 || MAX_ERR < 1 || MAX_ERR > 255 ||
        TIME_LIMIT < 1 || TIME_LIMIT > 255) begin : g_cfg_err
        $error("typing_tracker: parameter out of range");
    end

    state_t      state_q, state_nx;
    logic [9:0]  cur_nx;
    logic [7:0]  err_nx;
    logic [10:0] char_base;
    logic [5:0]  exp_char;
    logic        key_acc;
    logic        win, lose_err;

`ifdef TYPING_TIME_LIMIT_EN
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    logic [PW-1:0] presc_q, presc_nx;
    logic [7:0]    sec_nx;
    logic          lose_time;
`else
    // Countdown removed in this build: seconds output is a constant zero.
    assign sec_left = 8'd0;
`endif

    assign Q         = state_q;
    assign key_ready = (state_q == ST_RUN);
    assign key_acc   = key_valid && key_ready;
    // 11 bits holds 6*199+5; the index never wraps.
    assign char_base = 11'(cur) * 11'd6;
    assign exp_char  = text[char_base +: 6];

    // Next-state and counter update logic; RUN priority is WIN > error LOSE > timeout LOSE > PAUSE.
    always_comb begin
        state_nx  = state_q;
        cur_nx    = cur;
        err_nx    = err_cnt;
        win       = 1'b0;
        lose_err  = 1'b0;
`ifdef TYPING_TIME_LIMIT_EN
        presc_nx  = presc_q;
        sec_nx    = sec_left;
        lose_time = 1'b0;
`endif
        case (state_q)
            ST_STOP: begin
                if (start_btn) begin
                    state_nx = ST_RUN;
                    cur_nx   = 10'd0;
                    err_nx   = 8'd0;
`ifdef TYPING_TIME_LIMIT_EN
                    sec_nx   = 8'(TIME_LIMIT);
                    presc_nx = '0;
`endif
                end
            end
            ST_RUN: begin
                if (key_acc) begin
                    if (key_code == exp_char) begin
                        cur_nx = cur + 10'd1;
                        win    = (cur + 10'd1 == 10'(TEXT_LEN));
                    end else begin
                        err_nx   = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                        lose_err = ({1'b0, err_cnt} + 9'd1 == 9'(MAX_ERR));
                    end
                end
`ifdef TYPING_TIME_LIMIT_EN
                if (presc_q == PW'(CLK_HZ - 1)) begin
                    presc_nx  = '0;
                    sec_nx    = sec_left - 8'd1;
                    lose_time = (sec_left == 8'd1);
                end else begin
                    presc_nx  = presc_q + PW'(1);
                end
                if (win)                        state_nx = ST_WIN;
                else if (lose_err || lose_time) state_nx = ST_LOSE;
                else if (pause_btn)             state_nx = ST_PAUSE;
`else
                if (win)            state_nx = ST_WIN;
                else if (lose_err)  state_nx = ST_LOSE;
                else if (pause_btn) state_nx = ST_PAUSE;
`endif
            end
            ST_PAUSE: begin
                if (pause_btn) state_nx = ST_RUN;
            end
            ST_WIN, ST_LOSE: begin
                if (start_btn) state_nx = ST_STOP;
            end
            default: state_nx = ST_STOP;
        endcase
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= ST_STOP;
            cur      <= 10'd0;
            err_cnt  <= 8'd0;
`ifdef TYPING_TIME_LIMIT_EN
            sec_left <= 8'(TIME_LIMIT);
            presc_q  <= '0;
`endif
        end else begin
            state_q  <= state_nx;
            cur      <= cur_nx;
            err_cnt  <= err_nx;
`ifdef TYPING_TIME_LIMIT_EN
            sec_left <= sec_nx;
            presc_q  <= presc_nx;
`endif
        end
    end

endmodule
